// File: rtl/io_defs.sv
// Register map constants shared by the interval timer and its register port.
package io_defs;
    localparam int DATA_W = 16;

    localparam logic [3:0] TMR_CTRL        = 4'h0;
    localparam logic [3:0] TMR_PEND        = 4'h1;
    localparam logic [3:0] TMR_PERIOD_BASE = 4'h8;

    function automatic logic [3:0] period_addr(input int ch);
        return TMR_PERIOD_BASE + 4'(ch);
    endfunction
endpackage

// File: rtl/timer_channel.sv
// One interval channel: counts prescaler ticks and pulses fire at the end of each period.
module timer_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic             period_wr,
    output logic             fire
);
    logic [CNT_W-1:0] count_r;
    logic             period_zero_s;
    logic             at_end_s;

    assign period_zero_s = (period == {CNT_W{1'b0}});
    assign at_end_s      = !period_zero_s && (count_r == (period - {{(CNT_W-1){1'b0}}, 1'b1}));
    // Combinational so the top sets pending on the same edge the count wraps.
    assign fire          = en && tick && at_end_s;

    // Tick counter; held at zero while idle so re-enabling restarts a full period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (period_wr || !en || period_zero_s) begin
            count_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            if (at_end_s) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/interrupt_timer.sv
// Multi-channel interval timer: common prescaler, CTRL/PEND/PERIOD registers and
// level interrupt lines driven straight from the pending register.
module interrupt_timer
    import io_defs::*;
#(
    parameter int PRESCALE = 50000,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [7:0]        interruptions
);
    localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [7:0]     CH_MASK = 8'((32'd1 << NUM_CH) - 32'd1);

    logic [PS_W-1:0]   prescale_r;
    logic              tick_s;
    logic [7:0]        enable_r;
    logic [7:0]        oneshot_r;
    logic [7:0]        pending_r;
    logic [CNT_W-1:0]  period_r [NUM_CH];
    logic [DATA_W-1:0] rdata_r;

    logic [7:0]        fire_s;
    logic              wr_s;
    logic              rd_s;
    logic              ctrl_wr_s;
    logic              pend_wr_s;
    logic [NUM_CH-1:0] period_wr_s;
    logic [7:0]        clr_s;
    logic [7:0]        enable_next_s;
    logic [7:0]        pending_next_s;
    logic [DATA_W-1:0] rd_data_s;

    assign tick_s = (prescale_r == PS_LAST);

    // Free-running prescaler, independent of channel enables
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            prescale_r <= {PS_W{1'b0}};
        end else begin
            prescale_r <= prescale_r + {{(PS_W-1){1'b0}}, 1'b1};
        end
    end

    // Register port decode and next-state for enable/pending
    always_comb begin
        wr_s      = sel && we;
        rd_s      = sel && !we;
        ctrl_wr_s = wr_s && (addr == TMR_CTRL);
        pend_wr_s = wr_s && (addr == TMR_PEND);
        for (int i = 0; i < NUM_CH; i++) begin
            period_wr_s[i] = wr_s && (addr == period_addr(i));
        end
        // A CPU CTRL write overrides a simultaneous oneshot self-disable.
        if (ctrl_wr_s) begin
            enable_next_s = wdata[7:0] & CH_MASK;
        end else begin
            enable_next_s = enable_r & ~(fire_s & oneshot_r);
        end
        if (pend_wr_s) begin
            clr_s = wdata[7:0];
        end else begin
            clr_s = 8'h00;
        end
        // Fire is OR-ed in after the clear so a colliding event is never lost.
        pending_next_s = ((pending_r & ~clr_s) | fire_s) & CH_MASK;
    end

    // Read mux; unimplemented addresses and bits return zero
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        case (addr)
            TMR_CTRL: rd_data_s = {oneshot_r, enable_r};
            TMR_PEND: rd_data_s = {8'h00, pending_r};
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    rd_data_s = rd_data_s |
                        ({DATA_W{addr == period_addr(i)}} & DATA_W'(period_r[i]));
                end
            end
        endcase
    end

    // Control, pending and read-data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_r  <= 8'h00;
            oneshot_r <= 8'h00;
            pending_r <= 8'h00;
            rdata_r   <= {DATA_W{1'b0}};
        end else begin
            enable_r  <= enable_next_s;
            pending_r <= pending_next_s;
            if (ctrl_wr_s) begin
                oneshot_r <= wdata[15:8] & CH_MASK;
            end else begin
                oneshot_r <= oneshot_r;
            end
            if (rd_s) begin
                rdata_r <= rd_data_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Period registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (period_wr_s[i]) begin
                    period_r[i] <= CNT_W'(wdata);
                end else begin
                    period_r[i] <= period_r[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick_s),
            .en        (enable_r[g]),
            .period    (period_r[g]),
            .period_wr (period_wr_s[g]),
            .fire      (fire_s[g])
        );
    end

    for (genvar g = NUM_CH; g < 8; g++) begin : g_unused
        assign fire_s[g] = 1'b0;
    end

    assign rdata         = rdata_r;
    assign interruptions = pending_r;
endmodule

// File: tb/tb_interrupt_timer.sv
// Directed self-checking bench for interrupt_timer with PRESCALE=4, NUM_CH=4.
module tb_interrupt_timer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic [7:0]  interruptions;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit hi_seen = 1'b0;

    interrupt_timer #(
        .PRESCALE (4),
        .NUM_CH   (4),
        .CNT_W    (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sel           (sel),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .interruptions (interruptions)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (interruptions[7:4] != 4'h0) hi_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one bus cycle starting now (at a falling edge); sampled at the next rising edge.
    task automatic bus_drive(input logic w, input logic [3:0] a, input logic [15:0] d);
        sel = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        bus_drive(1'b1, a, d);
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        bus_drive(1'b0, a, 16'h0000);
        d = rdata;
    endtask

    task automatic wait_rise(input int b, input int max, output int stamp, output bit ok);
        ok = 1'b0;
        stamp = -1;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (interruptions[b]) begin
                ok = 1'b1;
                stamp = cyc;
            end
        end
    endtask

    initial begin
        logic [15:0] rd;
        int s1, s2, e, phase, w, bad;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_irq", interruptions, 8'h00);
        check("reset_rdata", rdata, 16'h0000);
        reset = 1'b1;
        read_reg(4'h1, rd);
        check("pend_after_reset", rd, 16'h0000);

        // Periodic channel 0, period 3 ticks = 12 clk
        write_reg(4'h8, 16'd3);
        write_reg(4'h0, 16'h0001);
        wait_rise(0, 100, s1, ok);
        check("ch0_first_fire", ok, 1);
        write_reg(4'h1, 16'h0001);
        check("ch0_cleared", interruptions[0], 1'b0);
        wait_rise(0, 100, s2, ok);
        check("ch0_second_fire", ok, 1);
        check("ch0_interval", s2 - s1, 12);
        write_reg(4'h0, 16'h0000);
        write_reg(4'h1, 16'h0001);

        // Oneshot channel 2
        write_reg(4'hA, 16'd2);
        write_reg(4'h0, 16'h0404);
        wait_rise(2, 100, s1, ok);
        check("ch2_oneshot_fire", ok, 1);
        read_reg(4'h0, rd);
        check("ctrl_after_oneshot", rd, 16'h0400);
        write_reg(4'h1, 16'h0004);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (interruptions[2]) bad++;
        end
        check("ch2_no_refire", bad, 0);

        // Set vs clear collision on channel 1, period 1
        write_reg(4'h9, 16'd1);
        write_reg(4'h0, 16'h0002);
        wait_rise(1, 40, e, ok);
        check("ch1_fire", ok, 1);
        phase = e % 4;
        bus_drive(1'b1, 4'h1, 16'h0002);
        check("ch1_clear_no_fire", interruptions[1], 1'b0);
        repeat (2) @(negedge clk);
        bus_drive(1'b1, 4'h1, 16'h0002);
        check("ch1_collision_kept", interruptions[1], 1'b1);
        write_reg(4'h0, 16'h0000);
        write_reg(4'h1, 16'h000F);
        check("all_cleared", interruptions, 8'h00);

        // Period rewrite on channel 3 restarts the count
        write_reg(4'hB, 16'd5);
        while ((cyc % 4) != phase) @(negedge clk);
        w = cyc + 1;
        bus_drive(1'b1, 4'h0, 16'h0008);
        while (cyc != w + 7) @(negedge clk);
        bus_drive(1'b1, 4'hB, 16'd5);
        wait_rise(3, 60, s1, ok);
        check("ch3_fire", ok, 1);
        check("ch3_fire_cycle", s1, w + 27);

        // PERIOD=0 never fires; CTRL write keeps pending; unmapped read
        write_reg(4'h8, 16'd0);
        write_reg(4'h0, 16'h0001);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (interruptions[0]) bad++;
        end
        check("period0_never_fires", bad, 0);
        read_reg(4'h1, rd);
        check("pend_kept_by_ctrl", rd, 16'h0008);
        read_reg(4'h5, rd);
        check("unmapped_read", rd, 16'h0000);
        write_reg(4'h5, 16'hFFFF);
        read_reg(4'hB, rd);
        check("period3_read", rd, 16'd5);
        read_reg(4'h0, rd);
        check("ctrl_read", rd, 16'h0001);

        // Asynchronous reset mid-run
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_irq", interruptions, 8'h00);
        check("async_reset_rdata", rdata, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        read_reg(4'h1, rd);
        check("pend_after_async_reset", rd, 16'h0000);
        read_reg(4'hB, rd);
        check("period_after_async_reset", rd, 16'h0000);
        check("upper_irq_zero", hi_seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
